// File: rtl/mib_slave.sv
// MIB bus slave: decodes a two-phase 24-bit address, collects 32-bit write data,
// issues one local command, and returns the ack or read data to the MIB master.
module mib_slave #(
  parameter logic [3:0]  P_MIB_MSN              = 4'h2,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic        i_sysclk,
  input  logic        i_srst_n,
  input  logic        i_mib_start,
  input  logic        i_mib_rd_wr_n,
  input  logic [15:0] i_mib_ad,
  output logic [15:0] o_mib_ad,
  output logic        o_mib_ad_oe,
  output logic        o_mib_slave_ack,
  output logic        o_cmd_sel,
  output logic        o_cmd_rd_wr_n,
  output logic [23:0] o_cmd_byte_addr,
  output logic [31:0] o_cmd_wdata,
  input  logic        i_cmd_ack,
  input  logic [31:0] i_cmd_rdata,
  output logic        o_cmd_timeout
);

  localparam int unsigned CNT_W = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR2, ST_WDATA1, ST_WDATA2,
    ST_CMD_WAIT, ST_WACK, ST_RDATA1, ST_RDATA2
  } state_e;

  state_e             state_q, state_d;
  logic [23:0]        addr_q, addr_d;
  logic               rd_q, rd_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        rdata_lo_q, rdata_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        mib_ad_q, mib_ad_d;
  logic               mib_ad_oe_q, mib_ad_oe_d;
  logic               mib_ack_q, mib_ack_d;
  logic               cmd_sel_q, cmd_sel_d;
  logic               cmd_rd_q, cmd_rd_d;
  logic [23:0]        cmd_addr_q, cmd_addr_d;
  logic [31:0]        cmd_wdata_q, cmd_wdata_d;
  logic               cmd_to_q, cmd_to_d;

  // State and output registers; every register clears on reset.
  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_lo_q  <= '0;
      cnt_q       <= '0;
      mib_ad_q    <= '0;
      mib_ad_oe_q <= 1'b0;
      mib_ack_q   <= 1'b0;
      cmd_sel_q   <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      rdata_lo_q  <= rdata_lo_d;
      cnt_q       <= cnt_d;
      mib_ad_q    <= mib_ad_d;
      mib_ad_oe_q <= mib_ad_oe_d;
      mib_ack_q   <= mib_ack_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_to_q    <= cmd_to_d;
    end
  end

  // Next-state logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    rdata_lo_d  = rdata_lo_q;
    cnt_d       = cnt_q;
    mib_ad_d    = '0;
    mib_ad_oe_d = 1'b0;
    mib_ack_d   = 1'b0;
    cmd_sel_d   = 1'b0;
    cmd_rd_d    = cmd_rd_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_to_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_mib_start) begin
          addr_d[23:8] = i_mib_ad;
          rd_d         = i_mib_rd_wr_n;
          state_d      = ST_ADDR2;
        end
      end
      ST_ADDR2: begin
        addr_d[7:0] = i_mib_ad[7:0];
        if (addr_q[23:20] != P_MIB_MSN) begin
          state_d = ST_IDLE;
        end else if (rd_q) begin
          state_d     = ST_CMD_WAIT;
          cmd_sel_d   = 1'b1;
          cnt_d       = '0;
          cmd_rd_d    = 1'b1;
          cmd_addr_d  = addr_d;
          cmd_wdata_d = '0;
        end else begin
          state_d = ST_WDATA1;
        end
      end
      ST_WDATA1: begin
        wdata_d[31:16] = i_mib_ad;
        state_d        = ST_WDATA2;
      end
      ST_WDATA2: begin
        wdata_d[15:0] = i_mib_ad;
        state_d       = ST_CMD_WAIT;
        cmd_sel_d     = 1'b1;
        cnt_d         = '0;
        cmd_rd_d      = 1'b0;
        cmd_addr_d    = addr_q;
        cmd_wdata_d   = wdata_d;
      end
      ST_CMD_WAIT: begin
        // cnt_q==0 is the select cycle, where an ack is not yet accepted
        if ((cnt_q != '0) && i_cmd_ack) begin
          mib_ack_d = 1'b1;
          if (rd_q) begin
            rdata_lo_d  = i_cmd_rdata[15:0];
            mib_ad_d    = i_cmd_rdata[31:16];
            mib_ad_oe_d = 1'b1;
            state_d     = ST_RDATA1;
          end else begin
            state_d = ST_WACK;
          end
        end else if (cnt_q == CNT_W'(P_CMD_ACK_TIMEOUT_CLKS)) begin
          cmd_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WACK: begin
        state_d = ST_IDLE;
      end
      ST_RDATA1: begin
        mib_ad_d    = rdata_lo_q;
        mib_ad_oe_d = 1'b1;
        mib_ack_d   = 1'b1;
        state_d     = ST_RDATA2;
      end
      ST_RDATA2: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_mib_ad        = mib_ad_q;
  assign o_mib_ad_oe     = mib_ad_oe_q;
  assign o_mib_slave_ack = mib_ack_q;
  assign o_cmd_sel       = cmd_sel_q;
  assign o_cmd_rd_wr_n   = cmd_rd_q;
  assign o_cmd_byte_addr = cmd_addr_q;
  assign o_cmd_wdata     = cmd_wdata_q;
  assign o_cmd_timeout   = cmd_to_q;

endmodule

// File: tb/tb_mib_slave.sv
// Testbench for mib_slave: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_mib_slave;

  localparam int TO  = 16;
  localparam logic [3:0] MSN = 4'h2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rdwr;
  logic [15:0] ad;
  logic [15:0] o_mib_ad;
  logic        o_mib_ad_oe;
  logic        o_mib_slave_ack;
  logic        o_cmd_sel;
  logic        o_cmd_rd_wr_n;
  logic [23:0] o_cmd_byte_addr;
  logic [31:0] o_cmd_wdata;
  logic        cmd_ack;
  logic [31:0] cmd_rdata;
  logic        o_cmd_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mib_slave dut (
    .i_sysclk        (clk),
    .i_srst_n        (rst_n),
    .i_mib_start     (start),
    .i_mib_rd_wr_n   (rdwr),
    .i_mib_ad        (ad),
    .o_mib_ad        (o_mib_ad),
    .o_mib_ad_oe     (o_mib_ad_oe),
    .o_mib_slave_ack (o_mib_slave_ack),
    .o_cmd_sel       (o_cmd_sel),
    .o_cmd_rd_wr_n   (o_cmd_rd_wr_n),
    .o_cmd_byte_addr (o_cmd_byte_addr),
    .o_cmd_wdata     (o_cmd_wdata),
    .i_cmd_ack       (cmd_ack),
    .i_cmd_rdata     (cmd_rdata),
    .o_cmd_timeout   (o_cmd_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference model: tracks a transaction by its cycle index t since the start was sampled.
  bit          busy = 1'b0;
  int          t, acc, s;
  bit          m_rd;
  logic [23:0] m_addr;
  logic [31:0] m_wdata = '0, m_rdata;
  logic [15:0] e_ad = '0;
  logic        e_oe = 1'b0, e_mack = 1'b0, e_sel = 1'b0, e_rdwr = 1'b0, e_to = 1'b0;
  logic [23:0] e_addr = '0;
  logic [31:0] e_wdata = '0;

  always @(posedge clk) begin
    e_sel = 1'b0; e_mack = 1'b0; e_oe = 1'b0; e_ad = '0; e_to = 1'b0;
    if (!rst_n) begin
      busy = 1'b0; e_rdwr = 1'b0; e_addr = '0; e_wdata = '0; m_wdata = '0;
    end else if (!busy) begin
      if (start) begin
        busy = 1'b1; t = 1; acc = 0; m_rd = rdwr; m_addr = {ad, 8'h00};
      end
    end else begin
      s = m_rd ? 2 : 4;
      if (t == 1) begin
        m_addr[7:0] = ad[7:0];
        if (m_addr[23:20] != MSN) busy = 1'b0;
      end
      if (t == 2 && !m_rd) m_wdata[31:16] = ad;
      if (t == 3 && !m_rd) m_wdata[15:0] = ad;
      if (acc == 0 && t > s && t <= s + TO && cmd_ack) begin
        acc = t; m_rdata = cmd_rdata;
      end else if (acc == 0 && t == s + TO) begin
        busy = 1'b0; e_to = 1'b1;
      end
      if (acc != 0 && !m_rd && t == acc + 1) busy = 1'b0;
      if (acc != 0 && t == acc + 2) busy = 1'b0;
      t++;
      if (busy) begin
        if (t == s) begin
          e_sel = 1'b1; e_rdwr = m_rd; e_addr = m_addr; e_wdata = m_rd ? 32'h0 : m_wdata;
        end
        if (acc != 0 && t == acc + 1) begin
          e_mack = 1'b1;
          if (m_rd) begin e_oe = 1'b1; e_ad = m_rdata[31:16]; end
        end
        if (acc != 0 && t == acc + 2) begin
          e_mack = 1'b1; e_oe = 1'b1; e_ad = m_rdata[15:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ad",    32'(o_mib_ad),        32'(e_ad));
      chk("m_oe",    32'(o_mib_ad_oe),     32'(e_oe));
      chk("m_ack",   32'(o_mib_slave_ack), 32'(e_mack));
      chk("m_sel",   32'(o_cmd_sel),       32'(e_sel));
      chk("m_rdwr",  32'(o_cmd_rd_wr_n),   32'(e_rdwr));
      chk("m_addr",  32'(o_cmd_byte_addr), 32'(e_addr));
      chk("m_wdata", o_cmd_wdata,          e_wdata);
      chk("m_to",    32'(o_cmd_timeout),   32'(e_to));
    end
  end

  // Local register block responder: mode 0 fixed delay, 1 random with stray acks, 2 never.
  int          resp_mode = 0;
  int          resp_dly  = 2;
  logic [31:0] resp_data = '0;
  int          pend      = -1;

  always @(negedge clk) begin
    cmd_ack   = 1'b0;
    cmd_rdata = (resp_mode == 1) ? $urandom : resp_data;
    if (!rst_n) begin
      pend = -1;
    end else begin
      if (o_cmd_sel && resp_mode != 2)
        pend = (resp_mode == 1) ? int'($urandom_range(0, 19)) : resp_dly;
      if (pend == 0) begin
        cmd_ack = 1'b1; pend = -1;
      end else if (pend > 0) begin
        pend--;
      end else if (resp_mode == 1 && $urandom_range(0, 9) == 0) begin
        cmd_ack = 1'b1;
      end
    end
  end

  task automatic do_write(input logic [23:0] addr, input logic [31:0] data, input bit inject);
    int n, pos;
    resp_mode = 0; resp_dly = 2;
    start = 1'b1; rdwr = 1'b0; ad = addr[23:8]; cyc();
    start = 1'b0; ad = {8'h00, addr[7:0]}; cyc();
    ad = data[31:16];
    if (inject) begin start = 1'b1; rdwr = 1'b1; end
    cyc();
    start = 1'b0; ad = data[15:0]; cyc();
    ad = '0;
    chk("wr_sel",   32'(o_cmd_sel), 32'h1);
    chk("wr_addr",  32'(o_cmd_byte_addr), 32'(addr));
    chk("wr_data",  o_cmd_wdata, data);
    chk("wr_dir",   32'(o_cmd_rd_wr_n), 32'h0);
    n = 0; pos = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (o_mib_slave_ack) begin n++; pos = i; end
    end
    chk("wr_ack_cnt", 32'(n), 32'd1);
    chk("wr_ack_pos", 32'(pos), 32'd3);
  endtask

  task automatic do_read(input logic [23:0] addr, input logic [31:0] data);
    resp_mode = 0; resp_dly = 2; resp_data = data;
    start = 1'b1; rdwr = 1'b1; ad = addr[23:8]; cyc();
    start = 1'b0; ad = {8'h00, addr[7:0]}; cyc();
    ad = '0;
    chk("rd_sel",  32'(o_cmd_sel), 32'h1);
    chk("rd_addr", 32'(o_cmd_byte_addr), 32'(addr));
    chk("rd_dir",  32'(o_cmd_rd_wr_n), 32'h1);
    chk("rd_oe0",  32'(o_mib_ad_oe), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 3) begin
        chk("rd_ack1", 32'(o_mib_slave_ack), 32'h1);
        chk("rd_oe1",  32'(o_mib_ad_oe), 32'h1);
        chk("rd_hi",   32'(o_mib_ad), 32'(data[31:16]));
      end else if (i == 4) begin
        chk("rd_ack2", 32'(o_mib_slave_ack), 32'h1);
        chk("rd_oe2",  32'(o_mib_ad_oe), 32'h1);
        chk("rd_lo",   32'(o_mib_ad), 32'(data[15:0]));
      end else begin
        chk("rd_oe_off", 32'(o_mib_ad_oe), 32'h0);
      end
    end
  endtask

  initial begin
    int n_sel, n_ack, tpos, n_to, pos;
    rst_n = 1'b0; start = 1'b0; rdwr = 1'b0; ad = '0;
    repeat (3) cyc();
    chk_en = 1'b1;
    chk("rst_oe",    32'(o_mib_ad_oe), 32'h0);
    chk("rst_ack",   32'(o_mib_slave_ack), 32'h0);
    chk("rst_sel",   32'(o_cmd_sel), 32'h0);
    chk("rst_addr",  32'(o_cmd_byte_addr), 32'h0);
    chk("rst_wdata", o_cmd_wdata, 32'h0);
    rst_n = 1'b1; cyc();

    do_write(24'h200004, 32'h01010202, 1'b0);
    do_read(24'h200000, 32'hCAFE1234);

    // Address outside this slave's window
    start = 1'b1; rdwr = 1'b1; ad = 16'h3000; cyc();
    start = 1'b0; ad = '0;
    n_sel = 0; n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (o_cmd_sel) n_sel++;
      if (o_mib_slave_ack) n_ack++;
    end
    chk("msn_sel", 32'(n_sel), 32'd0);
    chk("msn_ack", 32'(n_ack), 32'd0);
    do_read(24'h200010, 32'h5A5A0F0F);

    // Local ack never arrives
    resp_mode = 2;
    start = 1'b1; rdwr = 1'b1; ad = 16'h2000; cyc();
    start = 1'b0; ad = 16'h00FF; cyc();
    ad = '0;
    chk("to_sel", 32'(o_cmd_sel), 32'h1);
    tpos = 0; n_to = 0; n_ack = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (o_cmd_timeout) begin n_to++; if (tpos == 0) tpos = i; end
      if (o_mib_slave_ack) n_ack++;
    end
    chk("to_pos", 32'(tpos), 32'd17);
    chk("to_cnt", 32'(n_to), 32'd1);
    chk("to_ack", 32'(n_ack), 32'd0);

    do_write(24'h200008, 32'h0A0B0C0D, 1'b1);

    // Reset while read data is on the bus
    resp_mode = 0; resp_dly = 1; resp_data = 32'hCAFE1234;
    start = 1'b1; rdwr = 1'b1; ad = 16'h2000; cyc();
    start = 1'b0; ad = '0; cyc();
    pos = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (o_mib_ad_oe) begin pos = i; break; end
    end
    chk("rst_mid_pos", 32'(pos), 32'd2);
    rst_n = 1'b0; cyc();
    chk("rst_mid_oe",  32'(o_mib_ad_oe), 32'h0);
    chk("rst_mid_ack", 32'(o_mib_slave_ack), 32'h0);
    chk("rst_mid_ad",  32'(o_mib_ad), 32'h0);
    rst_n = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (o_mib_slave_ack) n_ack++;
    end
    chk("rst_mid_noack", 32'(n_ack), 32'd0);
    do_read(24'h200000, 32'hCAFE1234);

    // Random traffic, including starts while busy, stray acks and resets
    resp_mode = 1;
    repeat (4000) begin
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 4) == 0);
      rdwr  = 1'($urandom_range(0, 1));
      ad    = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ad[15:12] = MSN;
      cyc();
    end
    rst_n = 1'b1; start = 1'b0; ad = '0;
    repeat (30) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
